// File: rtl/mips_ctrl_defs.sv
// Shared definitions for the MIPS pipeline control blocks.
//   state_t   : hazard sequencer state encoding
//   REG_ZERO  : architectural zero register index (never a real dependency)
package mips_ctrl_defs;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the load currently in EX writes a
// register that the instruction in ID reads.
// Ports:
//   ex_mem_read  in  load in EX
//   ex_rt        in  load destination register
//   id_rs        in  rs of instruction in ID
//   id_rt        in  rt of instruction in ID
//   id_uses_rt   in  ID instruction actually reads rt
//   hazard       out stall required
module load_use_detect
    import mips_ctrl_defs::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       hazard
);

    // $zero is hardwired, so a load targeting it creates no dependency.
    assign hazard = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Handles load-use stalls, MEM-resolved branch flushes and data-memory wait
// freezes, with a watchdog on memory waits and a stall-cycle counter.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_rs, id_rt, id_uses_rt        ID-stage source operands
//   ex_mem_read, ex_rt              load in EX and its destination
//   mem_branch_tkn                  branch taken, resolved in MEM
//   dmem_req, dmem_ready            data memory access / completion
//   stat_clr                        clear stall_cycles
//   pc_en, ifid_en, exmem_en        latch load enables
//   ifid_flush, idex_flush,
//   exmem_flush, memwb_bubble       latch flush / bubble controls
//   err                             sticky memory-timeout error
//   stall_cycles                    saturating count of cycles with pc_en=0
//
// state    | meaning
// RUN      | normal flow; branch and load-use rules apply
// MEM_WAIT | data memory stalled, pipe frozen until dmem_ready
// ERROR    | memory wait exceeded TIMEOUT; frozen until reset
module pipeline_hazard_ctrl
    import mips_ctrl_defs::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_tkn,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             stat_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);

    // wait_cnt never needs to exceed TIMEOUT-1
    localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           load_use;
    logic           mem_freeze;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .hazard      (load_use)
    );

    // Once waiting, only dmem_ready releases the freeze; dmem_req is irrelevant.
    assign mem_freeze = !dmem_ready && ((state == MEM_WAIT) || ((state == RUN) && dmem_req));
    assign err        = (state == ERROR);

    // Outputs respond in the same cycle as the hazard; priority is
    // memory freeze > branch flush > load-use.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
        end else if ((state == ERROR) || mem_freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (mem_branch_tkn) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                        state    <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stat_clr) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, mem_branch_tkn;
    logic       dmem_req, dmem_ready, stat_clr;

    logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush, memwb_bubble, err;
    logic [31:0] stall_cycles;
    logic        w_pc_en, w_ifid_en, w_ifid_flush, w_idex_flush, w_exmem_en, w_exmem_flush, w_memwb_bubble, w_err;
    logic [3:0]  w_stall_cycles;

    logic [7:0] obs, obs4;
    assign obs  = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush, memwb_bubble, err};
    assign obs4 = {w_pc_en, w_ifid_en, w_ifid_flush, w_idex_flush, w_exmem_en, w_exmem_flush, w_memwb_bubble, w_err};

    // Output vectors {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush, memwb_bubble, err}
    localparam logic [7:0] O_RESET  = 8'b00110110;
    localparam logic [7:0] O_NORMAL = 8'b11001000;
    localparam logic [7:0] O_LDUSE  = 8'b00011000;
    localparam logic [7:0] O_BRANCH = 8'b11111100;
    localparam logic [7:0] O_FREEZE = 8'b00000010;
    localparam logic [7:0] O_ERROR  = 8'b00000011;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int m_wait;
    bit m_err;
    int sc;
    int sc4;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_tkn(mem_branch_tkn),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .stat_clr(stat_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble),
        .err(err), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_tkn(mem_branch_tkn),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .stat_clr(stat_clr),
        .pc_en(w_pc_en), .ifid_en(w_ifid_en), .ifid_flush(w_ifid_flush), .idex_flush(w_idex_flush),
        .exmem_en(w_exmem_en), .exmem_flush(w_exmem_flush), .memwb_bubble(w_memwb_bubble),
        .err(w_err), .stall_cycles(w_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs straight from the behavioural rules.
    function automatic logic [7:0] model_out();
        logic hz;
        if (!rst_n) return O_RESET;
        if (m_err) return O_ERROR;
        if (!dmem_ready && (m_wait > 0 || dmem_req)) return O_FREEZE;
        if (mem_branch_tkn) return O_BRANCH;
        hz = ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        if (hz) return O_LDUSE;
        return O_NORMAL;
    endfunction

    task automatic model_reset();
        m_wait = 0;
        m_err  = 1'b0;
        sc     = 0;
        sc4    = 0;
    endtask

    task automatic tick();
        logic [7:0] e;
        e = model_out();
        @(posedge clk);
        if (stat_clr) begin
            sc  = 0;
            sc4 = 0;
        end else if (!e[7]) begin
            sc++;
            if (sc4 < 15) sc4++;
        end
        if (!m_err) begin
            if (!dmem_ready && (m_wait > 0 || dmem_req)) begin
                m_wait++;
                if (m_wait >= TIMEOUT) m_err = 1'b1;
            end else begin
                m_wait = 0;
            end
        end
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                          input logic mr, input logic [4:0] ert, input logic br,
                          input logic req, input logic rdy, input logic clr);
        id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_read = mr; ex_rt = ert;
        mem_branch_tkn = br; dmem_req = req; dmem_ready = rdy; stat_clr = clr;
    endtask

    // Async reset asserted between edges; leaves rst_n low for the caller to sample.
    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b0;
        model_reset();
        #2;
        total++; if (obs !== O_RESET) $display("FAIL reset_outputs: got %b expected %b", obs, O_RESET); else passed++;
        total++; if (stall_cycles !== 32'd0) $display("FAIL reset_stall: got %0d expected 0", stall_cycles); else passed++;
        @(posedge clk); #1;
        release_reset();
        total++; if (obs !== O_NORMAL) $display("FAIL run_default: got %b expected %b", obs, O_NORMAL); else passed++;
        tick();
    endtask

    task automatic test_load_use();
        set_in(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 1, 0); #1;
        total++; if (obs !== O_LDUSE) $display("FAIL lu_rs: got %b expected %b", obs, O_LDUSE); else passed++;
        tick();
        total++; if (stall_cycles !== 32'd1) $display("FAIL lu_count: got %0d expected 1", stall_cycles); else passed++;
        set_in(5'd5, 5'd0, 0, 0, 5'd5, 0, 0, 1, 0); #1;
        total++; if (obs !== O_NORMAL) $display("FAIL lu_released: got %b expected %b", obs, O_NORMAL); else passed++;
        tick();
        set_in(5'd1, 5'd7, 0, 1, 5'd7, 0, 0, 1, 0); #1;
        total++; if (obs !== O_NORMAL) $display("FAIL lu_rt_unused: got %b expected %b", obs, O_NORMAL); else passed++;
        tick();
        set_in(5'd1, 5'd7, 1, 1, 5'd7, 0, 0, 1, 0); #1;
        total++; if (obs !== O_LDUSE) $display("FAIL lu_rt_used: got %b expected %b", obs, O_LDUSE); else passed++;
        tick();
        set_in(5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 1, 0); #1;
        total++; if (obs !== O_NORMAL) $display("FAIL lu_reg_zero: got %b expected %b", obs, O_NORMAL); else passed++;
        tick();
        total++; if (stall_cycles !== 32'd2) $display("FAIL lu_count2: got %0d expected 2", stall_cycles); else passed++;
    endtask

    task automatic test_branch();
        set_in(5'd9, 5'd0, 0, 1, 5'd9, 1, 0, 1, 0); #1;
        total++; if (obs !== O_BRANCH) $display("FAIL br_over_lu: got %b expected %b", obs, O_BRANCH); else passed++;
        tick();
        total++; if (stall_cycles !== 32'd2) $display("FAIL br_no_stall: got %0d expected 2", stall_cycles); else passed++;
    endtask

    task automatic test_mem_wait();
        int s0;
        s0 = sc;
        set_in(5'd3, 5'd0, 0, 1, 5'd3, 1, 1, 0, 0); #1;
        total++; if (obs !== O_FREEZE) $display("FAIL mw_enter: got %b expected %b", obs, O_FREEZE); else passed++;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        total++; if (obs !== O_FREEZE) $display("FAIL mw_hold_noreq: got %b expected %b", obs, O_FREEZE); else passed++;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
        total++; if (obs !== O_FREEZE) $display("FAIL mw_hold3: got %b expected %b", obs, O_FREEZE); else passed++;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); #1;
        total++; if (obs !== O_NORMAL) $display("FAIL mw_release: got %b expected %b", obs, O_NORMAL); else passed++;
        tick();
        total++; if (stall_cycles !== 32'(s0 + 3)) $display("FAIL mw_count: got %0d expected %0d", stall_cycles, s0 + 3); else passed++;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        total++; if (obs !== O_NORMAL) $display("FAIL mw_back_in_run: got %b expected %b", obs, O_NORMAL); else passed++;
        tick();
        // release cycle obeys load-use rule
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); #1; tick();
        set_in(5'd4, 5'd0, 0, 1, 5'd4, 0, 1, 1, 0); #1;
        total++; if (obs !== O_LDUSE) $display("FAIL mw_release_lu: got %b expected %b", obs, O_LDUSE); else passed++;
        tick();
        // reset while waiting returns straight to RUN
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); #1; tick();
        assert_reset();
        total++; if (obs !== O_RESET) $display("FAIL mw_reset_out: got %b expected %b", obs, O_RESET); else passed++;
        total++; if (stall_cycles !== 32'd0) $display("FAIL mw_reset_count: got %0d expected 0", stall_cycles); else passed++;
        release_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        total++; if (obs !== O_NORMAL) $display("FAIL mw_reset_run: got %b expected %b", obs, O_NORMAL); else passed++;
        tick();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < TIMEOUT; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
            total++; if (obs !== O_FREEZE) $display("FAIL to_frozen[%0d]: got %b expected %b", i, obs, O_FREEZE); else passed++;
            tick();
        end
        total++; if (stall_cycles !== 32'(TIMEOUT)) $display("FAIL to_count: got %0d expected %0d", stall_cycles, TIMEOUT); else passed++;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, i == 1, i != 2, 1, 0); #1;
            total++; if (obs !== O_ERROR) $display("FAIL to_sticky[%0d]: got %b expected %b", i, obs, O_ERROR); else passed++;
            tick();
        end
        total++; if (stall_cycles !== 32'(TIMEOUT + 3)) $display("FAIL to_err_count: got %0d expected %0d", stall_cycles, TIMEOUT + 3); else passed++;
        assert_reset();
        total++; if (obs !== O_RESET) $display("FAIL to_reset: got %b expected %b", obs, O_RESET); else passed++;
        release_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        total++; if (obs !== O_NORMAL) $display("FAIL to_recovered: got %b expected %b", obs, O_NORMAL); else passed++;
        tick();
    endtask

    task automatic test_stat_clr();
        set_in(5'd6, 5'd0, 0, 1, 5'd6, 0, 0, 1, 0); #1; tick();
        set_in(5'd6, 5'd0, 0, 1, 5'd6, 0, 0, 1, 1); #1;
        total++; if (obs !== O_LDUSE) $display("FAIL clr_stall_out: got %b expected %b", obs, O_LDUSE); else passed++;
        tick();
        total++; if (stall_cycles !== 32'd0) $display("FAIL clr_wins: got %0d expected 0", stall_cycles); else passed++;
        for (int i = 0; i < 20; i++) begin
            set_in(5'd6, 5'd0, 0, 1, 5'd6, 0, 0, 1, 0); #1; tick();
        end
        total++; if (w_stall_cycles !== 4'd15) $display("FAIL sat_w4: got %0d expected 15", w_stall_cycles); else passed++;
        total++; if (stall_cycles !== 32'd20) $display("FAIL sat_w32: got %0d expected 20", stall_cycles); else passed++;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); #1; tick();
        total++; if (w_stall_cycles !== 4'd0) $display("FAIL clr_w4: got %0d expected 0", w_stall_cycles); else passed++;
    endtask

    task automatic test_random();
        int busy;
        busy = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                assert_reset();
                total++; if (obs !== model_out()) $display("FAIL rnd_reset[%0d]: got %b expected %b", n, obs, model_out()); else passed++;
                release_reset();
            end
            if (busy == 0 && $urandom_range(0, 79) == 0) busy = 20;
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 2) == 0, (busy == 0) && ($urandom_range(0, 3) != 0),
                   $urandom_range(0, 19) == 0);
            if (busy > 0) begin
                busy--;
                dmem_req = 1'b1;
            end
            #1;
            total++; if (obs !== model_out()) $display("FAIL rnd_out[%0d]: got %b expected %b", n, obs, model_out()); else passed++;
            total++; if (obs4 !== model_out()) $display("FAIL rnd_out_w4[%0d]: got %b expected %b", n, obs4, model_out()); else passed++;
            tick();
            total++; if (stall_cycles !== 32'(sc)) $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", n, stall_cycles, sc); else passed++;
            total++; if (w_stall_cycles !== 4'(sc4)) $display("FAIL rnd_cnt_w4[%0d]: got %0d expected %0d", n, w_stall_cycles, sc4); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_stat_clr();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
